// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth sequential multiplier:
//   - state_t : controller state encoding (IDLE/BUSY/DONE)
//   - digit_t : Booth digit select (0, +1, +2, -1, -2)
//   - booth_digit() : maps an overlapping multiplier triplet to its digit
// -----------------------------------------------------------------------------
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef enum logic [2:0] {
      DIG_ZERO = 3'd0,
      DIG_P1   = 3'd1,
      DIG_P2   = 3'd2,
      DIG_M1   = 3'd3,
      DIG_M2   = 3'd4
   } digit_t;

   // Triplet is {b[2i+1], b[2i], b[2i-1]}; digit = -2*t2 + t1 + t0.
   function automatic digit_t booth_digit(input logic [2:0] triplet);
      digit_t d;
      case (triplet)
         3'b001, 3'b010: d = DIG_P1;
         3'b011:         d = DIG_P2;
         3'b100:         d = DIG_M2;
         3'b101, 3'b110: d = DIG_M1;
         default:        d = DIG_ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_pp_select.sv
// -----------------------------------------------------------------------------
// booth_pp_select
// Combinational Booth partial-product generator.
//   triplet_i : 3-bit overlapping multiplier triplet
//   mcand_i   : WIDTH-bit signed multiplicand
//   pp_o      : WIDTH+2-bit signed partial product d*mcand, d in {0,+-1,+-2}
// -----------------------------------------------------------------------------
module booth_pp_select
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       triplet_i,
   input  logic [WIDTH-1:0] mcand_i,
   output logic [WIDTH+1:0] pp_o
);

   localparam logic [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

   logic [WIDTH+1:0] m1;
   logic [WIDTH+1:0] m2;

   // Two guard bits so that +-2*mcand (including -2 * most-negative) fits.
   assign m1 = {{2{mcand_i[WIDTH-1]}}, mcand_i};
   assign m2 = {m1[WIDTH:0], 1'b0};

   always_comb begin
      pp_o = '0;
      case (booth_digit(triplet_i))
         DIG_P1:  pp_o = m1;
         DIG_P2:  pp_o = m2;
         DIG_M1:  pp_o = ~m1 + ONE;
         DIG_M2:  pp_o = ~m2 + ONE;
         default: pp_o = '0;
      endcase
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_r4_seq_mult
// Iterative signed radix-4 Booth multiplier, one Booth digit per cycle,
// WIDTH/2 iterations per product, valid/ready on input and output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b                : signed multiplicand / multiplier
//   out_valid/out_ready : product handshake (out_valid high only in DONE)
//   product             : signed a*b, 2*WIDTH bits, held outside DONE
//   busy                : high while iterating
// -----------------------------------------------------------------------------
module booth_r4_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int              PW       = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t             state_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH:0]     mplr_q;
   logic [PW-1:0]      acc_q;
   logic [PW-1:0]      product_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               in_ready_q;
   logic               out_valid_q;
   logic               busy_q;

   logic [WIDTH+1:0]   pp;
   logic [PW-1:0]      pp_ext;
   logic [PW-1:0]      pp_shifted;
   logic [PW-1:0]      acc_d;
   logic [CNT_W:0]     shamt;

   // mcand_q holds a as-is; sign extension happens inside the selector.
   booth_pp_select #(.WIDTH(WIDTH)) u_pp_select (
      .triplet_i (mplr_q[2:0]),
      .mcand_i   (mcand_q),
      .pp_o      (pp)
   );

   // Full sign extension of every partial product removes the need for
   // a sign-correction row; the adder simply wraps modulo 2^PW.
   assign pp_ext     = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp};
   assign shamt      = {cnt_q, 1'b0};
   assign pp_shifted = pp_ext << shamt;
   assign acc_d      = acc_q + pp_shifted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplr_q      <= '0;
         acc_q       <= '0;
         product_q   <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q    <= a;
                  mplr_q     <= {b, 1'b0};
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  state_q    <= BUSY;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            BUSY: begin
               acc_q  <= acc_d;
               // Arithmetic shift keeps the upper triplets sign-correct.
               mplr_q <= {{2{mplr_q[WIDTH]}}, mplr_q[WIDTH:2]};
               cnt_q  <= cnt_q + CNT_ONE;
               if (cnt_q == LAST_CNT) begin
                  state_q     <= DONE;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  product_q   <= acc_d;
               end
            end
            DONE: begin
               // Return to IDLE only; a new operand is taken next cycle.
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign product   = product_q;

endmodule
